// File: rtl/micro_sequencer_pkg.sv
// micro_seq_pkg: shared definitions for the microprogram sequencer.
//   - bit positions of every control-word field
//   - SEQ (next-address mode) encodings
//   - MS (condition select) encodings and the condition mux helper
package micro_seq_pkg;

    // Control word field positions
    localparam int NA_HI  = 27;
    localparam int NA_LO  = 20;
    localparam int MS_HI  = 19;
    localparam int MS_LO  = 17;
    localparam int MC_BIT = 16;
    localparam int IL_BIT = 15;
    localparam int PI_BIT = 14;
    localparam int PL_BIT = 13;
    localparam int SEQ_HI = 12;
    localparam int SEQ_LO = 11;
    localparam int MB_BIT = 9;
    localparam int MD_BIT = 3;
    localparam int RW_BIT = 2;
    localparam int MM_BIT = 1;
    localparam int MW_BIT = 0;

    typedef enum logic [1:0] {
        SEQ_NEXT   = 2'b00,
        SEQ_BRANCH = 2'b01,
        SEQ_CALL   = 2'b10,
        SEQ_RET    = 2'b11
    } seq_e;

    typedef enum logic [2:0] {
        MS_FALSE = 3'd0,
        MS_TRUE  = 3'd1,
        MS_C     = 3'd2,
        MS_V     = 3'd3,
        MS_Z     = 3'd4,
        MS_N     = 3'd5,
        MS_NC    = 3'd6,
        MS_NZ    = 3'd7
    } ms_e;

    function automatic logic cond_sel(input ms_e ms, input logic n, input logic z,
                                      input logic v, input logic c);
        logic r;
        r = 1'b0;
        case (ms)
            MS_FALSE: r = 1'b0;
            MS_TRUE:  r = 1'b1;
            MS_C:     r = c;
            MS_V:     r = v;
            MS_Z:     r = z;
            MS_N:     r = n;
            MS_NC:    r = ~c;
            MS_NZ:    r = ~z;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-store bus between the sequencer and its
// synchronous control-store RAM (1-cycle read latency).
//   car_nxt : read address presented by the sequencer
//   cw      : control word returned for the previous cycle's car_nxt
// Modports: master = sequencer side, slave = control-store side.
interface micro_sequencer_if #(
    parameter int CAR_W = 8,
    parameter int CW_W  = 32
);
    logic [CAR_W-1:0] car_nxt;
    logic [CW_W-1:0]  cw;

    modport master (output car_nxt, input cw);
    modport slave  (input car_nxt, output cw);
endinterface

// File: rtl/micro_sequencer_ret_stack.sv
// micro_ret_stack: microsubroutine return-address LIFO.
//   i_clk, i_rstn : clock, synchronous active-low reset (clears SP only)
//   i_push/i_data : push i_data (ignored when full)
//   i_pop         : discard top entry (ignored when empty)
//   o_top         : current top-of-stack entry (valid when !o_empty)
//   o_full/o_empty: SP == DEPTH / SP == 0
module micro_ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign wr_idx  = sp_q[IDX_W-1:0];
    // DEPTH is a power of two, so SP-1 in IDX_W bits also covers SP==DEPTH.
    assign top_idx = wr_idx - IDX_W'(1);
    assign o_top   = mem_q[top_idx];
    assign o_full  = (sp_q == SP_W'(DEPTH));
    assign o_empty = (sp_q == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sp_q <= '0;
        end else if (i_push && !o_full) begin
            mem_q[wr_idx] <= i_data;
            sp_q          <= sp_q + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer for the 16-bit CPU control path.
// Holds CAR, PC, IR and the next-address mux; subroutine returns live in
// micro_ret_stack.
//   i_clk, i_rstn        : clock, synchronous active-low reset
//   i_stall              : freeze CAR/PC/IR/SP/error flag, suppress MW/RW
//   i_instruction        : program-memory word, captured into IR on IL
//   i_n/i_z/i_v/i_c      : datapath status flags
//   cs (master)          : control-store bus (car_nxt out, cw in)
//   o_car, o_pc, o_ir    : current CAR, program counter, instruction register
//   o_dr/o_sa/o_sb/o_fs  : register and function selects from IR
//   o_mb..o_mw           : datapath controls from the control word
//   o_stk_err            : sticky stack overflow/underflow flag
// OPC_W must not exceed CAR_W; INSN_W is fixed at 32 for the IR field map.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int CAR_W       = 8,
    parameter int PC_W        = 8,
    parameter int INSN_W      = 32,
    parameter int OPC_W       = 7,
    parameter int CW_W        = 32,
    parameter int STACK_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_stall,
    input  logic [INSN_W-1:0] i_instruction,
    input  logic              i_n,
    input  logic              i_z,
    input  logic              i_v,
    input  logic              i_c,
    micro_sequencer_if.master cs,
    output logic [CAR_W-1:0]  o_car,
    output logic [PC_W-1:0]   o_pc,
    output logic [INSN_W-1:0] o_ir,
    output logic [3:0]        o_dr,
    output logic [3:0]        o_sa,
    output logic [3:0]        o_sb,
    output logic [4:0]        o_fs,
    output logic              o_mb,
    output logic              o_md,
    output logic              o_rw,
    output logic              o_mm,
    output logic              o_mw,
    output logic              o_stk_err
);
    logic [CAR_W-1:0]  car_q, car_d, car_inc, na, opc_car, stk_top;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic              stk_err_q, stk_err_d;
    logic              cw_vld_q;
    logic [CW_W-1:0]   cw;
    seq_e              seq;
    logic              cond, mc, il, pi, pl;
    logic              push, pop, stk_full, stk_empty;
    logic              unused_bits;

    // The word arriving in the first cycle after reset was addressed while
    // in reset, so it is treated as all-zero (a plain NEXT with no controls).
    assign cw = (i_rstn && cw_vld_q) ? cs.cw : '0;

    assign seq     = seq_e'(cw[SEQ_HI:SEQ_LO]);
    assign cond    = cond_sel(ms_e'(cw[MS_HI:MS_LO]), i_n, i_z, i_v, i_c);
    assign mc      = cw[MC_BIT];
    assign il      = cw[IL_BIT];
    assign pi      = cw[PI_BIT];
    assign pl      = cw[PL_BIT];
    assign car_inc = car_q + CAR_W'(1);
    assign na      = CAR_W'(cw[NA_HI:NA_LO]);
    assign opc_car = CAR_W'(ir_q[INSN_W-1 -: OPC_W]);

    always_comb begin
        car_d     = car_inc;
        push      = 1'b0;
        pop       = 1'b0;
        stk_err_d = stk_err_q;
        if (!i_rstn) begin
            car_d = '0;
        end else if (i_stall) begin
            car_d = car_q;
        end else if (mc) begin
            car_d = opc_car;
        end else begin
            case (seq)
                SEQ_NEXT:   car_d = car_inc;
                SEQ_BRANCH: if (cond) car_d = na;
                SEQ_CALL: begin
                    if (cond) begin
                        car_d = na;
                        if (stk_full) stk_err_d = 1'b1;
                        else          push      = 1'b1;
                    end
                end
                SEQ_RET: begin
                    if (stk_empty) begin
                        car_d     = '0;
                        stk_err_d = 1'b1;
                    end else begin
                        car_d = stk_top;
                        pop   = 1'b1;
                    end
                end
                default: car_d = car_inc;
            endcase
        end
    end

    // Adding the low PC_W bits modulo 2^PC_W equals adding their sign extension.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (!i_stall) begin
            if (pl && cond) pc_d = pc_q + ir_q[PC_W-1:0];
            else if (pi)    pc_d = pc_q + PC_W'(1);
            if (il)         ir_d = i_instruction;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            car_q     <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            stk_err_q <= 1'b0;
            cw_vld_q  <= 1'b0;
        end else begin
            car_q     <= car_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            stk_err_q <= stk_err_d;
            cw_vld_q  <= 1'b1;
        end
    end

    micro_ret_stack #(
        .W    (CAR_W),
        .DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_push (push),
        .i_pop  (pop),
        .i_data (car_inc),
        .o_top  (stk_top),
        .o_full (stk_full),
        .o_empty(stk_empty)
    );

    assign cs.car_nxt = car_d;
    assign o_car      = car_q;
    assign o_pc       = pc_q;
    assign o_ir       = ir_q;
    assign o_dr       = ir_q[24:21];
    assign o_sa       = ir_q[20:17];
    assign o_sb       = ir_q[16:13];
    assign o_fs       = ir_q[4:0];
    assign o_mb       = cw[MB_BIT];
    assign o_md       = cw[MD_BIT];
    assign o_mm       = cw[MM_BIT];
    assign o_rw       = cw[RW_BIT] & ~i_stall;
    assign o_mw       = cw[MW_BIT] & ~i_stall;
    assign o_stk_err  = stk_err_q;

    assign unused_bits = ^{cw, ir_q};
endmodule
